// File: rtl/dp_mem_responder.sv
// dp_mem_responder: arbitrates ifetch/data requests onto one memory bus, with LL/SC link tracking
module dp_mem_responder #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  input  logic        halt,
  output logic        mREN,
  output logic        mWEN,
  output logic [31:0] maddr,
  output logic [31:0] mstore,
  input  logic [31:0] mload,
  input  logic        mready,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        link_valid
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, DREQ, IREQ, DONE} state_t;
  state_t state, state_n;
  logic wr, wr_n, atom, atom_n;
  logic [CW-1:0] starve_cnt, starve_n;
  logic ihit_n, dhit_n, mren_n, mwen_n, lv_n;
  logic [31:0] maddr_n, mstore_n, imemload_n, dmemload_n, link_addr, la_n;
  logic dreq, starved, igrant, snoop_link, sc_ok;
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
  endfunction
  assign dreq       = dmemREN | dmemWEN;
  assign starved    = starve_cnt == CW'(STARVE_LIMIT);
  assign igrant     = imemREN & (~dreq | starved);
  assign snoop_link = snoop_valid & same_word(snoop_addr, link_addr);
  assign sc_ok      = link_valid & same_word(link_addr, dmemaddr) & ~snoop_link;
  always_comb begin
    state_n    = state;
    wr_n       = wr;
    atom_n     = atom;
    starve_n   = starve_cnt;
    ihit_n     = 1'b0;
    dhit_n     = 1'b0;
    mren_n     = mREN;
    mwen_n     = mWEN;
    maddr_n    = maddr;
    mstore_n   = mstore;
    imemload_n = imemload;
    dmemload_n = dmemload;
    lv_n       = link_valid;
    la_n       = link_addr;
    case (state)
      IDLE: if (!halt) begin
        if (igrant) begin
          state_n  = IREQ;
          maddr_n  = imemaddr;
          mren_n   = 1'b1;
          starve_n = '0;
        end else if (dreq) begin
          wr_n     = dmemWEN;
          atom_n   = datomic;
          maddr_n  = dmemaddr;
          mstore_n = dmemstore;
          starve_n = (imemREN && !starved) ? starve_cnt + 1'b1 : starve_cnt;
          if (dmemWEN && datomic && !sc_ok) begin
            // failed SC completes without touching memory
            state_n    = DONE;
            dhit_n     = 1'b1;
            dmemload_n = 32'h0;
            lv_n       = 1'b0;
          end else begin
            state_n = DREQ;
            mren_n  = ~dmemWEN;
            mwen_n  = dmemWEN;
          end
        end
      end
      DREQ: if (mready) begin
        state_n = DONE;
        mren_n  = 1'b0;
        mwen_n  = 1'b0;
        dhit_n  = 1'b1;
        if (!wr) begin
          dmemload_n = mload;
          lv_n       = atom ? 1'b1 : link_valid;
          la_n       = atom ? maddr : link_addr;
        end else if (atom) begin
          dmemload_n = 32'h1;
          lv_n       = 1'b0;
        end else if (same_word(maddr, link_addr)) begin
          lv_n = 1'b0;
        end
      end
      IREQ: if (mready) begin
        state_n    = DONE;
        mren_n     = 1'b0;
        ihit_n     = 1'b1;
        imemload_n = mload;
      end
      DONE: state_n = IDLE;
    endcase
    // snoops and halt override any link update made this cycle
    if ((snoop_valid && same_word(snoop_addr, la_n)) || halt) lv_n = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wr         <= 1'b0;
      atom       <= 1'b0;
      starve_cnt <= '0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      mREN       <= 1'b0;
      mWEN       <= 1'b0;
      maddr      <= 32'h0;
      mstore     <= 32'h0;
      imemload   <= 32'h0;
      dmemload   <= 32'h0;
      link_valid <= 1'b0;
      link_addr  <= 32'h0;
    end else begin
      state      <= state_n;
      wr         <= wr_n;
      atom       <= atom_n;
      starve_cnt <= starve_n;
      ihit       <= ihit_n;
      dhit       <= dhit_n;
      mREN       <= mren_n;
      mWEN       <= mwen_n;
      maddr      <= maddr_n;
      mstore     <= mstore_n;
      imemload   <= imemload_n;
      dmemload   <= dmemload_n;
      link_valid <= lv_n;
      link_addr  <= la_n;
    end
  end
endmodule
